// File: rtl/dmem_arbiter32.sv
// Round-robin arbiter sharing one single-port data memory between a CPU port and a
// debug/DMA port; handles sub-word loads/stores (read-modify-write) and flags bad accesses.
module dmem_arbiter32 #(
   parameter int unsigned N         = 32,
   parameter int unsigned ADDR_BITS = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   rq_valid,
   output logic [1:0]   rq_ready,
   input  logic         rq_we0,
   input  logic         rq_we1,
   input  logic [1:0]   rq_size0,
   input  logic [1:0]   rq_size1,
   input  logic         rq_unsigned0,
   input  logic         rq_unsigned1,
   input  logic [N-1:0] rq_addr0,
   input  logic [N-1:0] rq_addr1,
   input  logic [N-1:0] rq_wdata0,
   input  logic [N-1:0] rq_wdata1,
   output logic [1:0]   rsp_valid,
   output logic [N-1:0] rsp_rdata,
   output logic         rsp_err,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           grant;
   logic           take;
   logic           last_grant_q;
   logic           port_q;
   logic           we_q;
   logic           uns_q;
   logic [1:0]     size_q;
   logic [N-1:0]   addr_q;
   logic [N-1:0]   wdata_q;
   logic           acc_err;
   logic [7:0]     byte_lane;
   logic [15:0]    half_lane;
   logic [N-1:0]   load_data;
   logic [N-1:0]   merged;

   // Grant: the lone valid port, or on a tie the port that did not win last time.
   always_comb begin
      grant = 1'b0;
      if (rq_valid == 2'b10) begin
         grant = 1'b1;
      end else if (rq_valid == 2'b11) begin
         grant = ~last_grant_q;
      end
   end

   // Access legality of the latched request.
   always_comb begin
      acc_err = 1'b0;
      case (size_q)
         2'b00:   acc_err = 1'b0;
         2'b01:   acc_err = addr_q[0];
         2'b10:   acc_err = (addr_q[1:0] != 2'b00);
         default: acc_err = 1'b1;
      endcase
      if (addr_q[N-1:ADDR_BITS] != '0) begin
         acc_err = 1'b1;
      end
   end

   // Load lane extraction/extension and store merge over the combinational read data.
   always_comb begin
      byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_data = mem_rdata;
      merged    = wdata_q;
      case (size_q)
         2'b00: begin
            load_data = {{(N-8){byte_lane[7] & ~uns_q}}, byte_lane};
            merged    = mem_rdata;
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_data = {{(N-16){half_lane[15] & ~uns_q}}, half_lane};
            merged    = mem_rdata;
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            load_data = mem_rdata;
            merged    = wdata_q;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; handshake and memory strobes are decoded straight from state.
   always_comb begin
      state_d   = state_q;
      take      = 1'b0;
      rq_ready  = 2'b00;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (rq_valid != 2'b00) begin
               take     = 1'b1;
               rq_ready = grant ? 2'b10 : 2'b01;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            mem_addr = {addr_q[N-1:2], 2'b00};
            if (we_q && !acc_err) begin
               mem_we    = 1'b1;
               mem_wdata = merged;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture, round-robin history and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= 2'b00;
         addr_q       <= '0;
         wdata_q      <= '0;
         rsp_valid    <= 2'b00;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         if (take) begin
            last_grant_q <= grant;
            port_q       <= grant;
            we_q         <= grant ? rq_we1       : rq_we0;
            uns_q        <= grant ? rq_unsigned1 : rq_unsigned0;
            size_q       <= grant ? rq_size1     : rq_size0;
            addr_q       <= grant ? rq_addr1     : rq_addr0;
            wdata_q      <= grant ? rq_wdata1    : rq_wdata0;
         end
         rsp_valid <= 2'b00;
         if (state_q == ACCESS) begin
            rsp_valid <= port_q ? 2'b10 : 2'b01;
            rsp_err   <= acc_err;
            rsp_rdata <= (we_q || acc_err) ? '0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter32.sv
// Self-checking bench for dmem_arbiter32: directed cases plus randomized traffic
// checked against a byte-array reference memory.
module tb_dmem_arbiter32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rq_valid;
   logic [1:0]  rq_ready;
   logic        we0, we1, un0, un1;
   logic [1:0]  sz0, sz1;
   logic [31:0] a0, a1, wd0, wd1;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int we_count = 0;

   logic [31:0] mem [1024];
   bit          mem_wr [1024];
   logic [7:0]  ref_bytes [4096];

   always #5 clk = ~clk;

   dmem_arbiter32 dut (
      .clk(clk), .rst_n(rst_n),
      .rq_valid(rq_valid), .rq_ready(rq_ready),
      .rq_we0(we0), .rq_we1(we1),
      .rq_size0(sz0), .rq_size1(sz1),
      .rq_unsigned0(un0), .rq_unsigned1(un1),
      .rq_addr0(a0), .rq_addr1(a1),
      .rq_wdata0(wd0), .rq_wdata1(wd1),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] seed_word(input logic [9:0] i);
      return ({22'd0, i} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] tb_word(input int i);
      return mem_wr[i] ? mem[i] : seed_word(10'(i));
   endfunction

   // Memory behind the arbiter: combinational read, write on the rising edge.
   assign mem_rdata = tb_word(int'(mem_addr[11:2]));

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[11:2]]    <= mem_wdata;
         mem_wr[mem_addr[11:2]] <= 1'b1;
         we_count               <= we_count + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b;
      b = int'(a % 4096) - int'(a % 4);
      return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
   endfunction

   // Reference: byte-addressed memory, little-endian, loads extended to 32 bits.
   task automatic ref_access(input logic we, input logic [1:0] sz, input logic un,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] d, output logic e);
      int nb;
      logic [63:0] v;
      nb = 1 << sz;
      e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
          (sz == 2'd2 && (a % 4) != 0) || (a >= 32'h1000);
      d = '0;
      if (e) return;
      if (we) begin
         for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_bytes[int'(a) + i];
         if (!un && v[8*nb-1]) begin
            for (int k = 8*nb; k < 64; k++) v[k] = 1'b1;
         end
         d = v[31:0];
      end
   endtask

   task automatic set_port(input int p, input logic we, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd);
      if (p == 0) begin
         we0 = we; sz0 = sz; un0 = un; a0 = a; wd0 = wd;
      end else begin
         we1 = we; sz1 = sz; un1 = un; a1 = a; wd1 = wd;
      end
   endtask

   // One full transaction on port p, checked cycle by cycle against the reference.
   task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input string tag,
                         output logic [31:0] rd);
      logic [31:0] exp_d;
      logic        exp_e;
      int          n;
      rd = '0;
      @(negedge clk);
      set_port(p, we, sz, un, a, wd);
      rq_valid[p] = 1'b1;
      #1;
      n = 0;
      while (rq_ready[p] !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({tag, "_ready"}, {31'd0, rq_ready[p]}, 32'd1);
      if (rq_ready[p] !== 1'b1) begin
         rq_valid[p] = 1'b0;
         return;
      end
      ref_access(we, sz, un, a, wd, exp_d, exp_e);
      @(posedge clk); #1;
      rq_valid[p] = 1'b0;
      chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we & ~exp_e});
      chk({tag, "_mem_addr"}, mem_addr, a - (a % 4));
      chk({tag, "_mem_wdata"}, mem_wdata, (we && !exp_e) ? ref_word(a) : 32'd0);
      chk({tag, "_early"}, {30'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, (p == 0) ? 32'd1 : 32'd2);
      chk({tag, "_rdata"}, rsp_rdata, exp_d);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
      rd = rsp_rdata;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {30'd0, rsp_valid}, 32'd0);
      chk({tag, "_hold"}, rsp_rdata, exp_d);
   endtask

   logic [31:0] rd;
   logic [31:0] w;
   logic [1:0]  ord [4];
   logic [31:0] exp_rd [4];
   int          got, n, wc, bad;
   int          rp, rr;
   logic        rwe, run;
   logic [1:0]  rsz;
   logic [31:0] raddr;

   initial begin
      rst_n = 1'b0;
      rq_valid = 2'b00;
      set_port(0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      set_port(1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 1024; i++) begin
         w = seed_word(10'(i));
         for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {30'd0, rq_ready}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Word store then load
      wc = we_count;
      do_req(0, 1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF, "t1_st", rd);
      chk("t1_we_once", 32'(we_count - wc), 32'd1);
      do_req(0, 1'b0, 2'd2, 1'b0, 32'h010, 32'd0, "t1_ld", rd);
      chk("t1_value", rd, 32'hDEAD_BEEF);

      // Sub-word read-modify-write
      do_req(0, 1'b1, 2'd2, 1'b0, 32'h020, 32'h1122_3344, "t2_stw", rd);
      do_req(0, 1'b1, 2'd0, 1'b0, 32'h021, 32'h0000_00AA, "t2_stb", rd);
      do_req(0, 1'b0, 2'd2, 1'b0, 32'h020, 32'd0, "t2_ld1", rd);
      chk("t2_byte_merge", rd, 32'h1122_AA44);
      do_req(0, 1'b1, 2'd1, 1'b0, 32'h022, 32'h0000_BEEF, "t2_sth", rd);
      do_req(0, 1'b0, 2'd2, 1'b0, 32'h020, 32'd0, "t2_ld2", rd);
      chk("t2_half_merge", rd, 32'hBEEF_AA44);

      // Sign / zero extension
      do_req(0, 1'b1, 2'd2, 1'b0, 32'h030, 32'h0000_8080, "t3_st", rd);
      do_req(0, 1'b0, 2'd0, 1'b0, 32'h030, 32'd0, "t3_lbs", rd);
      chk("t3_byte_signed", rd, 32'hFFFF_FF80);
      do_req(0, 1'b0, 2'd0, 1'b1, 32'h030, 32'd0, "t3_lbu", rd);
      chk("t3_byte_unsigned", rd, 32'h0000_0080);
      do_req(0, 1'b0, 2'd1, 1'b0, 32'h030, 32'd0, "t3_lhs", rd);
      chk("t3_half_signed", rd, 32'hFFFF_8080);

      // Port 1 access, leaving port 1 as the last winner
      do_req(1, 1'b0, 2'd2, 1'b0, 32'h020, 32'd0, "t4_p1", rd);
      chk("t4_p1_value", rd, 32'hBEEF_AA44);

      // Both ports requesting continuously: strict alternation starting with port 0
      ord = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_rd = '{32'hDEAD_BEEF, 32'hBEEF_AA44, 32'hDEAD_BEEF, 32'hBEEF_AA44};
      @(negedge clk);
      set_port(0, 1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
      set_port(1, 1'b0, 2'd2, 1'b0, 32'h020, 32'd0);
      rq_valid = 2'b11;
      got = 0;
      n = 0;
      while (got < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (rsp_valid != 2'b00) begin
            chk($sformatf("t4_order%0d", got), {30'd0, rsp_valid}, {30'd0, ord[got]});
            chk($sformatf("t4_rdata%0d", got), rsp_rdata, exp_rd[got]);
            got++;
         end
      end
      rq_valid = 2'b00;
      chk("t4_resp_count", 32'(got), 32'd4);

      // Error cases never write memory
      wc = we_count;
      do_req(0, 1'b1, 2'd1, 1'b0, 32'h003, 32'h0000_1234, "t5_half_mis", rd);
      do_req(0, 1'b0, 2'd2, 1'b0, 32'h002, 32'd0, "t5_word_mis", rd);
      do_req(1, 1'b1, 2'd3, 1'b0, 32'h040, 32'hFFFF_FFFF, "t5_size3", rd);
      do_req(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, "t5_range_ld", rd);
      do_req(1, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h5555_5555, "t5_range_st", rd);
      chk("t5_no_write", 32'(we_count - wc), 32'd0);
      chk("t5_word0", tb_word(0), ref_word(32'h000));

      // Randomized traffic against the reference
      for (int it = 0; it < 80; it++) begin
         rp = int'($urandom_range(0, 1));
         rwe = 1'($urandom_range(0, 1));
         run = 1'($urandom_range(0, 1));
         rr = int'($urandom_range(0, 15));
         rsz = (rr == 15) ? 2'd3 : 2'(rr % 3);
         raddr = 32'h100 + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) raddr = raddr | (32'h1000 << $urandom_range(0, 19));
         do_req(rp, rwe, rsz, run, raddr, $urandom, $sformatf("rnd%0d", it), rd);
      end

      // Reset while a store is in ACCESS
      @(negedge clk);
      set_port(0, 1'b1, 2'd2, 1'b0, 32'h050, 32'h1234_5678);
      rq_valid = 2'b01;
      #1;
      chk("t6_ready", {30'd0, rq_ready}, 32'd1);
      @(posedge clk); #1;
      rq_valid = 2'b00;
      chk("t6_access_we", {31'd0, mem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_we_drop", {31'd0, mem_we}, 32'd0);
      chk("t6_addr_drop", mem_addr, 32'd0);
      @(posedge clk); #1;
      chk("t6_no_rsp", {30'd0, rsp_valid}, 32'd0);
      chk("t6_word_kept", tb_word(32'h050 / 4), ref_word(32'h050));
      @(negedge clk);
      rst_n = 1'b1;
      set_port(0, 1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
      set_port(1, 1'b0, 2'd2, 1'b0, 32'h020, 32'd0);
      rq_valid = 2'b11;
      n = 0;
      while (rsp_valid == 2'b00 && n < 20) begin
         @(negedge clk); n++;
      end
      chk("t6_first_grant", {30'd0, rsp_valid}, 32'd1);
      chk("t6_first_rdata", rsp_rdata, 32'hDEAD_BEEF);
      rq_valid = 2'b00;
      repeat (4) @(negedge clk);

      // Whole-memory comparison against the reference
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (tb_word(i) !== ref_word(32'(4 * i))) bad++;
      end
      chk("final_memory_diffs", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
